// File: rtl/cmp_result_tracker_if.sv
// Sample and result bundle between the comparator control logic and cmp_result_tracker.
interface cmp_result_tracker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             clr;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic [3:0]       run_len;
  logic             locked;
  logic             changed;
  logic             err;

  modport master (
    output in_valid, gt, eq, lt, clr,
    input  gt_cnt, eq_cnt, lt_cnt, total_cnt, run_len, locked, changed, err
  );

  modport slave (
    input  in_valid, gt, eq, lt, clr,
    output gt_cnt, eq_cnt, lt_cnt, total_cnt, run_len, locked, changed, err
  );
endinterface

// File: rtl/cmp_result_tracker.sv
// Registered consumer of comparator result lines: one-hot check, saturating
// per-category counts, equal-run lock tracking and change/fault reporting.
module cmp_result_tracker #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned RUN_TARGET = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_tracker_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StTrack, StLocked, StFault} state_e;
  typedef enum logic [1:0] {ResNone, ResGt, ResEq, ResLt} res_e;

  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [3:0]       RunTarget = 4'(RUN_TARGET);

  state_e           r_state;
  res_e             r_last;
  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_total_cnt;
  logic [3:0]       r_run_len;
  logic             r_locked;
  logic             r_changed;
  logic             r_err;

  logic [1:0]       w_hits;
  logic             w_sample;
  logic             w_onehot;
  res_e             w_res;
  logic [3:0]       w_run_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  // Classify the incoming sample; FAULT state and clr both mask it.
  always_comb begin
    w_hits   = {1'b0, bus.gt} + {1'b0, bus.eq} + {1'b0, bus.lt};
    w_sample = bus.in_valid & ~bus.clr & (r_state != StFault);
    w_onehot = (w_hits == 2'd1);
    w_res    = ResNone;
    if (bus.gt) begin
      w_res = ResGt;
    end else if (bus.eq) begin
      w_res = ResEq;
    end else if (bus.lt) begin
      w_res = ResLt;
    end
  end

  // Next run length for an accepted sample: eq extends (saturating), gt/lt break it.
  always_comb begin
    w_run_next = 4'd0;
    if (w_res == ResEq) begin
      w_run_next = (r_run_len >= RunTarget) ? RunTarget : r_run_len + 4'd1;
    end
  end

  // Tracker state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_last      <= ResNone;
      r_gt_cnt    <= '0;
      r_eq_cnt    <= '0;
      r_lt_cnt    <= '0;
      r_total_cnt <= '0;
      r_run_len   <= 4'd0;
      r_locked    <= 1'b0;
      r_changed   <= 1'b0;
      r_err       <= 1'b0;
    end else if (bus.clr) begin
      r_state     <= StIdle;
      r_last      <= ResNone;
      r_gt_cnt    <= '0;
      r_eq_cnt    <= '0;
      r_lt_cnt    <= '0;
      r_total_cnt <= '0;
      r_run_len   <= 4'd0;
      r_locked    <= 1'b0;
      r_changed   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (w_sample) begin
        if (w_onehot) begin
          r_total_cnt <= sat_inc(r_total_cnt);
          if (w_res == ResGt) r_gt_cnt <= sat_inc(r_gt_cnt);
          if (w_res == ResEq) r_eq_cnt <= sat_inc(r_eq_cnt);
          if (w_res == ResLt) r_lt_cnt <= sat_inc(r_lt_cnt);
          // The first sample after reset/clr has nothing to differ from.
          r_changed <= (r_last != ResNone) && (r_last != w_res);
          r_last    <= w_res;
          r_run_len <= w_run_next;
          // Covers IDLE->LOCKED when the target is 1, TRACK->LOCKED and LOCKED hold.
          if ((w_res == ResEq) && (w_run_next == RunTarget)) begin
            r_state  <= StLocked;
            r_locked <= 1'b1;
          end else begin
            r_state  <= StTrack;
            r_locked <= 1'b0;
          end
        end else begin
          r_state  <= StFault;
          r_locked <= 1'b0;
          r_err    <= 1'b1;
        end
      end
    end
  end

  assign bus.gt_cnt    = r_gt_cnt;
  assign bus.eq_cnt    = r_eq_cnt;
  assign bus.lt_cnt    = r_lt_cnt;
  assign bus.total_cnt = r_total_cnt;
  assign bus.run_len   = r_run_len;
  assign bus.locked    = r_locked;
  assign bus.changed   = r_changed;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker: directed scenarios plus random traffic against
// a behavioural model, on a wide instance (8-bit counts, target 3) and a
// narrow one (2-bit counts, target 1).
module tb_cmp_result_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_result_tracker_if #(.CNT_W(8)) a_if ();
  cmp_result_tracker_if #(.CNT_W(2)) b_if ();

  cmp_result_tracker #(.CNT_W(8), .RUN_TARGET(3)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
  cmp_result_tracker #(.CNT_W(2), .RUN_TARGET(1)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int total = 0;
  int bad   = 0;

  // Behavioural model, index 0 = instance a, 1 = instance b.
  int MAXV [2] = '{255, 3};
  int RT   [2] = '{3, 1};
  int m_gt [2], m_eq [2], m_lt [2], m_tot [2], m_run [2];
  int m_last [2];  // -1 none, 0 gt, 1 eq, 2 lt
  bit m_locked [2], m_changed [2], m_err [2];

  logic [70:0] obs_a, obs_b;
  assign obs_a = {8'd0, a_if.gt_cnt, 8'd0, a_if.eq_cnt, 8'd0, a_if.lt_cnt, 8'd0, a_if.total_cnt,
                  a_if.run_len, a_if.locked, a_if.changed, a_if.err};
  assign obs_b = {14'd0, b_if.gt_cnt, 14'd0, b_if.eq_cnt, 14'd0, b_if.lt_cnt, 14'd0,
                  b_if.total_cnt, b_if.run_len, b_if.locked, b_if.changed, b_if.err};

  function automatic logic [70:0] exp_vec(input int k);
    return {16'(m_gt[k]), 16'(m_eq[k]), 16'(m_lt[k]), 16'(m_tot[k]), 4'(m_run[k]),
            m_locked[k], m_changed[k], m_err[k]};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_gt[k] = 0; m_eq[k] = 0; m_lt[k] = 0; m_tot[k] = 0; m_run[k] = 0;
      m_last[k] = -1; m_locked[k] = 0; m_changed[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit g, input bit e, input bit l, input bit c);
    int n;
    int cat;
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        m_gt[k] = 0; m_eq[k] = 0; m_lt[k] = 0; m_tot[k] = 0; m_run[k] = 0;
        m_last[k] = -1; m_locked[k] = 0; m_changed[k] = 0; m_err[k] = 0;
      end else begin
        m_changed[k] = 0;
        if (v && !m_err[k]) begin
          n = int'(g) + int'(e) + int'(l);
          if (n == 1) begin
            cat = g ? 0 : (e ? 1 : 2);
            if (cat == 0) m_gt[k] = sat(m_gt[k], MAXV[k]);
            if (cat == 1) m_eq[k] = sat(m_eq[k], MAXV[k]);
            if (cat == 2) m_lt[k] = sat(m_lt[k], MAXV[k]);
            m_tot[k]     = sat(m_tot[k], MAXV[k]);
            m_changed[k] = (m_last[k] != -1) && (m_last[k] != cat);
            m_last[k]    = cat;
            if (cat == 1) begin
              m_run[k]    = sat(m_run[k], RT[k]);
              m_locked[k] = (m_run[k] == RT[k]);
            end else begin
              m_run[k]    = 0;
              m_locked[k] = 0;
            end
          end else begin
            m_err[k]    = 1;
            m_locked[k] = 0;
          end
        end
      end
    end
  endtask

  // Drive one cycle of stimulus to both instances; returns 1 ns after the edge.
  task automatic cycle(input bit v, input bit g, input bit e, input bit l, input bit c);
    a_if.in_valid = v; a_if.gt = g; a_if.eq = e; a_if.lt = l; a_if.clr = c;
    b_if.in_valid = v; b_if.gt = g; b_if.eq = e; b_if.lt = l; b_if.clr = c;
    @(posedge clk);
    model_step(v, g, e, l, c);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (obs_a !== 71'd0) begin
      bad++; $display("FAIL reset_a got=%h exp=0", obs_a);
    end
    total++;
    if (obs_b !== 71'd0) begin
      bad++; $display("FAIL reset_b got=%h exp=0", obs_b);
    end
  endtask

  task automatic test_eq_lock();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 0, 0);
      total++;
      if (a_if.run_len !== 4'(i + 1) || a_if.changed !== 1'b0 || a_if.locked !== (i == 2)) begin
        bad++;
        $display("FAIL eq_lock step=%0d got run=%0d chg=%b lk=%b exp run=%0d chg=0 lk=%b",
                 i, a_if.run_len, a_if.changed, a_if.locked, i + 1, (i == 2));
      end
      total++;
      if (obs_b !== exp_vec(1)) begin
        bad++; $display("FAIL eq_lock_b step=%0d got=%h exp=%h", i, obs_b, exp_vec(1));
      end
    end
    total++;
    if (a_if.eq_cnt !== 8'd3 || a_if.total_cnt !== 8'd3) begin
      bad++; $display("FAIL eq_lock_cnt got eq=%0d tot=%0d exp 3/3", a_if.eq_cnt, a_if.total_cnt);
    end
  endtask

  task automatic test_changed();
    bit g [4] = '{1, 1, 0, 0};
    bit l [4] = '{0, 0, 1, 0};
    bit e [4] = '{0, 0, 0, 1};
    bit x [4] = '{0, 0, 1, 1};
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, g[i], e[i], l[i], 0);
      total++;
      if (a_if.changed !== x[i]) begin
        bad++; $display("FAIL changed step=%0d got=%b exp=%b", i, a_if.changed, x[i]);
      end
      total++;
      if (obs_b !== exp_vec(1)) begin
        bad++; $display("FAIL changed_b step=%0d got=%h exp=%h", i, obs_b, exp_vec(1));
      end
    end
    total++;
    if (a_if.gt_cnt !== 8'd2 || a_if.lt_cnt !== 8'd1 || a_if.eq_cnt !== 8'd1 ||
        a_if.run_len !== 4'd1) begin
      bad++;
      $display("FAIL changed_cnt got gt=%0d lt=%0d eq=%0d run=%0d exp 2/1/1/1",
               a_if.gt_cnt, a_if.lt_cnt, a_if.eq_cnt, a_if.run_len);
    end
  endtask

  task automatic test_unlock();
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    total++;
    if (a_if.locked !== 1'b1 || a_if.run_len !== 4'd3) begin
      bad++; $display("FAIL unlock_pre got lk=%b run=%0d exp 1/3", a_if.locked, a_if.run_len);
    end
    cycle(1, 0, 0, 1, 0);
    total++;
    if (a_if.locked !== 1'b0 || a_if.run_len !== 4'd0 || a_if.lt_cnt !== 8'd2 ||
        a_if.changed !== 1'b1) begin
      bad++;
      $display("FAIL unlock got lk=%b run=%0d lt=%0d chg=%b exp 0/0/2/1",
               a_if.locked, a_if.run_len, a_if.lt_cnt, a_if.changed);
    end
    total++;
    if (obs_b !== exp_vec(1)) begin
      bad++; $display("FAIL unlock_b got=%h exp=%h", obs_b, exp_vec(1));
    end
  endtask

  task automatic test_fault();
    cycle(1, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0);
    total++;
    if (a_if.err !== 1'b1 || a_if.locked !== 1'b0 || a_if.gt_cnt !== 8'd2 ||
        a_if.eq_cnt !== 8'd3 || a_if.lt_cnt !== 8'd2 || a_if.total_cnt !== 8'd7 ||
        a_if.changed !== 1'b0) begin
      bad++;
      $display("FAIL fault_frozen got err=%b lk=%b gt=%0d eq=%0d lt=%0d tot=%0d exp 1/0/2/3/2/7",
               a_if.err, a_if.locked, a_if.gt_cnt, a_if.eq_cnt, a_if.lt_cnt, a_if.total_cnt);
    end
    total++;
    if (obs_b !== exp_vec(1)) begin
      bad++; $display("FAIL fault_b got=%h exp=%h", obs_b, exp_vec(1));
    end
    cycle(0, 0, 0, 0, 1);
    total++;
    if (obs_a !== 71'd0) begin
      bad++; $display("FAIL fault_clr got=%h exp=0", obs_a);
    end
  endtask

  task automatic test_saturate();
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 0);
      total++;
      if (b_if.gt_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || b_if.total_cnt !== b_if.gt_cnt ||
          b_if.eq_cnt !== 2'd0) begin
        bad++;
        $display("FAIL saturate step=%0d got gt=%0d tot=%0d exp %0d", i, b_if.gt_cnt,
                 b_if.total_cnt, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    total++;
    if (a_if.gt_cnt !== 8'd5) begin
      bad++; $display("FAIL saturate_a got=%0d exp=5", a_if.gt_cnt);
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    total++;
    if (a_if.eq_cnt !== 8'd2) begin
      bad++; $display("FAIL async_pre got=%0d exp=2", a_if.eq_cnt);
    end
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs_a !== 71'd0 || obs_b !== 71'd0) begin
      bad++; $display("FAIL async_rst got a=%h b=%h exp=0", obs_a, obs_b);
    end
    #1;
    rst = 1'b0;
    cycle(1, 0, 1, 0, 1);
    total++;
    if (a_if.eq_cnt !== 8'd0 || obs_a !== exp_vec(0)) begin
      bad++; $display("FAIL clr_priority got eq=%0d exp=0", a_if.eq_cnt);
    end
    cycle(1, 0, 1, 0, 0);
    total++;
    if (a_if.eq_cnt !== 8'd1 || obs_b !== exp_vec(1)) begin
      bad++; $display("FAIL after_rst got eq=%0d exp=1", a_if.eq_cnt);
    end
  endtask

  task automatic test_random();
    bit v, g, e, l, c;
    int r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        {g, e, l} = 3'($urandom_range(0, 7));
        if ({g, e, l} == 3'b001) {g, e, l} = 3'b011;
        if ({g, e, l} == 3'b010) {g, e, l} = 3'b110;
        if ({g, e, l} == 3'b100) {g, e, l} = 3'b000;
      end else begin
        r = $urandom_range(0, 2);
        {g, e, l} = (r == 0) ? 3'b100 : ((r == 1) ? 3'b010 : 3'b001);
      end
      cycle(v, g, e, l, c);
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL random_a cyc=%0d got=%h exp=%h", i, obs_a, exp_vec(0));
      end
      total++;
      if (obs_b !== exp_vec(1)) begin
        bad++; $display("FAIL random_b cyc=%0d got=%h exp=%h", i, obs_b, exp_vec(1));
      end
    end
  endtask

  initial begin
    a_if.in_valid = 0; a_if.gt = 0; a_if.eq = 0; a_if.lt = 0; a_if.clr = 0;
    b_if.in_valid = 0; b_if.gt = 0; b_if.eq = 0; b_if.lt = 0; b_if.clr = 0;
    model_reset();
    #2;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_eq_lock();
    test_changed();
    test_unlock();
    test_fault();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
